// File: rtl/draw_pkg.sv
// Shared definitions for the draw_* rasteriser blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package draw_pkg;

  // Control FSM encoding shared by the draw_* blocks.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Visible screen area; pixels at or beyond these limits are clipped.
  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;

endpackage

// File: rtl/draw_rect_scan.sv
// Raster scan datapath: offset counters, cursor, and last/select/visible flags.
// Latency: flags are combinational from the registered cursor; state moves one pixel per i_adv.
// Backpressure: holds every register while i_adv is low.
module draw_rect_scan
  import draw_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SIZE_W   = 5,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_load,
  input  logic              i_adv,
  input  logic [X_W-1:0]    i_x,
  input  logic [Y_W-1:0]    i_y,
  input  logic [SIZE_W-1:0] i_w,
  input  logic [SIZE_W-1:0] i_h,
  input  logic              i_outline,
  output logic [X_W-1:0]    o_px,
  output logic [Y_W-1:0]    o_py,
  output logic              o_sel,
  output logic              o_vis,
  output logic              o_last
);

  // One extra cursor bit so a coordinate carry lands off-screen instead of wrapping.
  localparam logic [X_W:0] LP_SCR_W = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] LP_SCR_H = (Y_W+1)'(SCREEN_H);

  logic [X_W:0]    r_x_base;
  logic [X_W:0]    r_cx;
  logic [Y_W:0]    r_cy;
  logic [SIZE_W-1:0] r_w;
  logic [SIZE_W-1:0] r_h;
  logic [SIZE_W-1:0] r_dx;
  logic [SIZE_W-1:0] r_dy;
  logic            r_outline;

  logic w_dx_end;
  logic w_dy_end;

  assign w_dx_end = (r_dx == (r_w - SIZE_W'(1)));
  assign w_dy_end = (r_dy == (r_h - SIZE_W'(1)));

  assign o_px   = r_cx[X_W-1:0];
  assign o_py   = r_cy[Y_W-1:0];
  assign o_sel  = !r_outline || (r_dx == '0) || (r_dy == '0) || w_dx_end || w_dy_end;
  assign o_vis  = (r_cx < LP_SCR_W) && (r_cy < LP_SCR_H);
  assign o_last = w_dx_end && w_dy_end;

  // Latch the rectangle on load, then walk it in raster order, dx innermost.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_x_base  <= '0;
      r_cx      <= '0;
      r_cy      <= '0;
      r_w       <= '0;
      r_h       <= '0;
      r_dx      <= '0;
      r_dy      <= '0;
      r_outline <= 1'b0;
    end else if (i_load) begin
      r_x_base  <= {1'b0, i_x};
      r_cx      <= {1'b0, i_x};
      r_cy      <= {1'b0, i_y};
      r_w       <= i_w;
      r_h       <= i_h;
      r_dx      <= '0;
      r_dy      <= '0;
      r_outline <= i_outline;
    end else if (i_adv) begin
      if (w_dx_end) begin
        r_dx <= '0;
        r_cx <= r_x_base;
        r_dy <= r_dy + SIZE_W'(1);
        r_cy <= r_cy + (Y_W+1)'(1);
      end else begin
        r_dx <= r_dx + SIZE_W'(1);
        r_cx <= r_cx + (X_W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/draw_rect.sv
// Rectangle rasteriser (filled or outline) driving one VGA pixel write per advance.
// Latency: first write in cycle 2 after start; done in cycle w*h+2 with no stalls.
// Backpressure: vga_ready low on a visible pixel freezes the scan and all outputs.
module draw_rect
  import draw_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int C_W      = 3,
  parameter int SIZE_W   = 5,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  input  logic [SIZE_W-1:0] rect_w,
  input  logic [SIZE_W-1:0] rect_h,
  input  logic [C_W-1:0]    colour,
  input  logic              outline,
  output logic [X_W-1:0]    vga_x,
  output logic [Y_W-1:0]    vga_y,
  output logic [C_W-1:0]    vga_colour,
  output logic              vga_write,
  input  logic              vga_ready
);

  state_t r_state;
  state_t w_state_nxt;
  logic [C_W-1:0] r_colour;

  logic w_load;
  logic w_emit;
  logic w_adv;
  logic [X_W-1:0] w_px;
  logic [Y_W-1:0] w_py;
  logic w_sel;
  logic w_vis;
  logic w_last;

  assign w_load = (r_state == ST_LOAD);
  assign w_emit = (r_state == ST_EMIT);

  // Skipped (clipped or unselected) pixels advance unconditionally.
  assign w_adv = w_emit && (!vga_write || vga_ready);

  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_DONE);
  assign vga_write  = w_emit && w_sel && w_vis;
  assign vga_x      = w_emit ? w_px : '0;
  assign vga_y      = w_emit ? w_py : '0;
  assign vga_colour = w_emit ? r_colour : '0;

  draw_rect_scan #(
    .X_W      (X_W),
    .Y_W      (Y_W),
    .SIZE_W   (SIZE_W),
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_scan (
    .i_clk     (clock),
    .i_reset   (reset),
    .i_load    (w_load),
    .i_adv     (w_adv),
    .i_x       (x),
    .i_y       (y),
    .i_w       (rect_w),
    .i_h       (rect_h),
    .i_outline (outline),
    .o_px      (w_px),
    .o_py      (w_py),
    .o_sel     (w_sel),
    .o_vis     (w_vis),
    .o_last    (w_last)
  );

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Colour is captured alongside the geometry so later input changes are ignored.
  always_ff @(posedge clock) begin
    if (reset)       r_colour <= '0;
    else if (w_load) r_colour <= colour;
  end

  // Next-state: zero-sized rectangles skip straight to DONE from LOAD.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (rect_w == '0 || rect_h == '0) w_state_nxt = ST_DONE;
        else                              w_state_nxt = ST_EMIT;
      end
      ST_EMIT: if (w_adv && w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule
